// File: rtl/md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// md_issue_ctrl
//   EX-stage initiator for the MultDiv unit. Accepts HI/LO-class instructions,
//   launches multiply/divide operations, tracks the unit's BUSY flag, holds the
//   architectural HI/LO shadow registers, and stalls the pipeline whenever a
//   request cannot be serviced. A watchdog raises a sticky timeout flag if the
//   unit stays busy for too long.
//
// Parameters
//   MAX_CYC     watchdog limit in RUN cycles
//
// Ports
//   clk, reset  clock, asynchronous active-low reset
//   req_valid   EX holds a HI/LO-class instruction
//   req_op      000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//               100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO
//   req_rs/rt   operands (req_rs is the MTHI/MTLO source)
//   flush       kill the current EX request
//   req_ready   request accepted this cycle
//   rd_valid    MFHI/MFLO result valid (combinational)
//   rd_data     MFHI/MFLO result, 0 when rd_valid is low
//   md_A/md_B   registered operands to MultDiv
//   md_start    registered one-cycle launch pulse
//   md_Op       registered MultDiv opcode
//   md_BUSY     MultDiv busy flag
//   md_HI/LO    MultDiv results, valid once BUSY falls
//   md_timeout  sticky watchdog flag
// -----------------------------------------------------------------------------
module md_issue_ctrl #(
    parameter int unsigned MAX_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    input  logic        flush,
    output logic        req_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] md_A,
    output logic [31:0] md_B,
    output logic        md_start,
    output logic [1:0]  md_Op,
    input  logic        md_BUSY,
    input  logic [31:0] md_HI,
    input  logic [31:0] md_LO,
    output logic        md_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MFHI  = 3'b100,
        OP_MFLO  = 3'b101,
        OP_MTHI  = 3'b110,
        OP_MTLO  = 3'b111
    } op_t;

    localparam int unsigned   CNT_W    = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYC - 1);

    state_t           state_q, state_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    op_t              req_op_e;
    logic             req_live;

    assign req_op_e = op_t'(req_op);
    // A flushed request is dead: it neither reads, writes nor launches.
    assign req_live = req_valid & ~flush;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        start_d   = 1'b0;
        cnt_d     = '0;
        timeout_d = timeout_q;
        req_ready = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_live) begin
                    unique case (req_op_e)
                        OP_MFHI: begin
                            req_ready = 1'b1;
                            rd_valid  = 1'b1;
                            rd_data   = hi_q;
                        end
                        OP_MFLO: begin
                            req_ready = 1'b1;
                            rd_valid  = 1'b1;
                            rd_data   = lo_q;
                        end
                        OP_MTHI: begin
                            req_ready = 1'b1;
                            hi_d      = req_rs;
                        end
                        OP_MTLO: begin
                            req_ready = 1'b1;
                            lo_d      = req_rs;
                        end
                        default: begin
                            // A still-busy unit (e.g. left over from before a
                            // reset) cannot take a new operation.
                            if (!md_BUSY) begin
                                req_ready = 1'b1;
                                a_d       = req_rs;
                                b_d       = req_rt;
                                op_d      = req_op[1:0];
                                start_d   = 1'b1;
                                state_d   = ST_LAUNCH;
                            end
                        end
                    endcase
                end
            end

            ST_LAUNCH: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // cnt_q == 0 marks the first RUN cycle: the unit only raises
                // BUSY on the edge ending LAUNCH, so a low BUSY here is stale.
                if ((cnt_q != '0) && !md_BUSY) begin
                    hi_d    = md_HI;
                    lo_d    = md_LO;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            start_q   <= start_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign md_A       = a_q;
    assign md_B       = b_q;
    assign md_Op      = op_q;
    assign md_start   = start_q;
    assign md_timeout = timeout_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_md_issue_ctrl
//   Self-checking bench for md_issue_ctrl. A behavioural MultDiv keeps BUSY
//   high 5 cycles for mult and 10 for div, starting the edge after md_start
//   (optionally one cycle later, to probe the first-RUN-cycle rule). Launches
//   and MF reads are checked against scoreboard queues filled when requests
//   are driven. A second instance with MAX_CYC=8 and a never-finishing unit
//   exercises the watchdog.
// -----------------------------------------------------------------------------
module tb_md_issue_ctrl;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MFHI  = 3'b100;
    localparam logic [2:0] OP_MFLO  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        fl;
        logic        late;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } launch_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        flush;
    logic        req_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [31:0] md_A;
    logic [31:0] md_B;
    logic        md_start;
    logic [1:0]  md_Op;
    logic        md_BUSY;
    logic [31:0] md_HI;
    logic [31:0] md_LO;
    logic        md_timeout;

    logic        wd_valid;
    logic [2:0]  wd_op;
    logic        wd_ready;
    logic        wd_rd_valid;
    logic [31:0] wd_rd_data;
    logic [31:0] wd_A;
    logic [31:0] wd_B;
    logic        wd_start;
    logic [1:0]  wd_Op;
    logic        wd_busy = 1'b0;
    logic        wd_timeout;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        late_mode;
    logic [31:0] rd_q[$];
    launch_t     launch_q[$];
    vec_t        vecs[33];

    md_issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .flush      (flush),
        .req_ready  (req_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .md_A       (md_A),
        .md_B       (md_B),
        .md_start   (md_start),
        .md_Op      (md_Op),
        .md_BUSY    (md_BUSY),
        .md_HI      (md_HI),
        .md_LO      (md_LO),
        .md_timeout (md_timeout)
    );

    md_issue_ctrl #(.MAX_CYC(8)) dut_wd (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (wd_valid),
        .req_op     (wd_op),
        .req_rs     (req_rs),
        .req_rt     (req_rt),
        .flush      (1'b0),
        .req_ready  (wd_ready),
        .rd_valid   (wd_rd_valid),
        .rd_data    (wd_rd_data),
        .md_A       (wd_A),
        .md_B       (wd_B),
        .md_start   (wd_start),
        .md_Op      (wd_Op),
        .md_BUSY    (wd_busy),
        .md_HI      (32'hdeadbeef),
        .md_LO      (32'hfeedface),
        .md_timeout (wd_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural MultDiv ----------------
    function automatic logic [63:0] md_calc(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            2'b00:   return {{32{a[31]}}, a} * {{32{b[31]}}, b};
            2'b01:   return {32'b0, a} * {32'b0, b};
            2'b10:   return {sa % sb, sa / sb};
            default: return {a % b, a / b};
        endcase
    endfunction

    logic [3:0]  m_cnt  = '0;
    logic [3:0]  m_len  = '0;
    logic        m_pend = 1'b0;
    logic [63:0] m_res  = '0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;

    always @(posedge clk) begin
        if (md_start) begin
            m_res <= md_calc(md_Op, md_A, md_B);
            if (late_mode) begin
                m_pend <= 1'b1;
                m_len  <= md_Op[1] ? 4'd10 : 4'd5;
            end else begin
                m_cnt  <= md_Op[1] ? 4'd10 : 4'd5;
            end
        end else if (m_pend) begin
            m_pend <= 1'b0;
            m_cnt  <= m_len;
        end else if (m_cnt != 4'd0) begin
            m_cnt <= m_cnt - 4'd1;
            if (m_cnt == 4'd1) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
        end
    end

    assign md_BUSY = (m_cnt != 4'd0);
    assign md_HI   = m_hi;
    assign md_LO   = m_lo;

    // Watchdog instance: the unit goes busy on launch and never finishes.
    always @(posedge clk) begin
        if (wd_start) wd_busy <= 1'b1;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares every launch and every MF result.
    always @(negedge clk) begin
        launch_t     exp_l;
        logic [31:0] exp_d;
        if (md_start) begin
            if (launch_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_start: got md_start=1 expected 0 (t=%0t)", $time);
            end else begin
                exp_l = launch_q.pop_front();
                check("launch_op", 64'(md_Op), 64'(exp_l.op));
                check("launch_A",  64'(md_A),  64'(exp_l.a));
                check("launch_B",  64'(md_B),  64'(exp_l.b));
            end
        end
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 data=%0h expected none (t=%0t)",
                         rd_data, $time);
            end else begin
                exp_d = rd_q.pop_front();
                check("rd_data", 64'(rd_data), 64'(exp_d));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input int idx, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic fl, input logic [31:0] exp_rd,
                         input int exp_stall);
        int stalls;
        if (!fl && (op == OP_MFHI || op == OP_MFLO)) rd_q.push_back(exp_rd);
        if (!fl && !op[2]) launch_q.push_back('{op: op[1:0], a: rs, b: rt});
        req_valid = 1'b1;
        req_op    = op;
        req_rs    = rs;
        req_rt    = rt;
        flush     = fl;
        stalls    = 0;
        if (fl) begin
            @(negedge clk);
        end else begin
            forever begin
                @(negedge clk);
                if (req_ready) break;
                stalls++;
                if (stalls > 100) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL vec%0d_ready_timeout: got no req_ready in 100 cycles", idx);
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        if (!fl && exp_stall >= 0) check($sformatf("vec%0d_stall", idx), 64'(stalls), 64'(exp_stall));
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic fl, input logic late, input logic [31:0] exp_rd,
                                input int exp_stall);
        return '{op: op, rs: rs, rt: rt, fl: fl, late: late, exp_rd: exp_rd, exp_stall: exp_stall};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not reach its end");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vecs[0]  = mk(OP_MFHI,  32'h0,        32'h0,        1'b0, 1'b0, 32'h00000000, 0);
        vecs[1]  = mk(OP_MULTU, 32'h7fffffff, 32'hffffffff, 1'b0, 1'b0, 32'h0,        0);
        vecs[2]  = mk(OP_MFHI,  32'h0,        32'h0,        1'b0, 1'b0, 32'h7ffffffe, 7);
        vecs[3]  = mk(OP_MFLO,  32'h0,        32'h0,        1'b0, 1'b0, 32'h80000001, 0);
        vecs[4]  = mk(OP_MULT,  32'h7fffffff, 32'hffffffff, 1'b0, 1'b0, 32'h0,        0);
        vecs[5]  = mk(OP_MFLO,  32'h0,        32'h0,        1'b0, 1'b0, 32'h80000001, 7);
        vecs[6]  = mk(OP_MFHI,  32'h0,        32'h0,        1'b0, 1'b0, 32'hffffffff, 0);
        vecs[7]  = mk(OP_DIV,   32'h00000007, 32'hfffffffe, 1'b0, 1'b1, 32'h0,        0);
        vecs[8]  = mk(OP_MFLO,  32'h0,        32'h0,        1'b0, 1'b0, 32'hfffffffd, 13);
        vecs[9]  = mk(OP_MFHI,  32'h0,        32'h0,        1'b0, 1'b0, 32'h00000001, 0);
        vecs[10] = mk(OP_MTHI,  32'h12345678, 32'h0,        1'b0, 1'b0, 32'h0,        0);
        vecs[11] = mk(OP_MFHI,  32'h0,        32'h0,        1'b0, 1'b0, 32'h12345678, 0);
        vecs[12] = mk(OP_MFLO,  32'h0,        32'h0,        1'b0, 1'b0, 32'hfffffffd, 0);
        vecs[13] = mk(OP_MULT,  32'h7fffffff, 32'hffffffff, 1'b0, 1'b0, 32'h0,        0);
        vecs[14] = mk(OP_MTHI,  32'hcafef00d, 32'h0,        1'b0, 1'b0, 32'h0,        7);
        vecs[15] = mk(OP_MFLO,  32'h0,        32'h0,        1'b0, 1'b0, 32'h80000001, 0);
        vecs[16] = mk(OP_MFHI,  32'h0,        32'h0,        1'b0, 1'b0, 32'hcafef00d, 0);
        vecs[17] = mk(OP_MULTU, 32'h7fffffff, 32'hffffffff, 1'b0, 1'b0, 32'h0,        0);
        vecs[18] = mk(OP_MTLO,  32'h0badc0de, 32'h0,        1'b0, 1'b0, 32'h0,        7);
        vecs[19] = mk(OP_MFLO,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0badc0de, 0);
        vecs[20] = mk(OP_MFHI,  32'h0,        32'h0,        1'b0, 1'b0, 32'h7ffffffe, 0);
        vecs[21] = mk(OP_MULT,  32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h0,        -1);
        vecs[22] = mk(OP_MTHI,  32'hffff0000, 32'h0,        1'b1, 1'b0, 32'h0,        -1);
        vecs[23] = mk(OP_MFLO,  32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        -1);
        vecs[24] = mk(OP_MFHI,  32'h0,        32'h0,        1'b0, 1'b0, 32'h7ffffffe, 0);
        vecs[25] = mk(OP_MFLO,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0badc0de, 0);
        vecs[26] = mk(OP_DIVU,  32'hffffffff, 32'h00000010, 1'b0, 1'b0, 32'h0,        0);
        vecs[27] = mk(OP_MFLO,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0fffffff, 12);
        vecs[28] = mk(OP_MFHI,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0000000f, 0);
        vecs[29] = mk(OP_MULT,  32'h00000003, 32'hfffffffb, 1'b0, 1'b0, 32'h0,        0);
        vecs[30] = mk(OP_MULTU, 32'h00000003, 32'hfffffffb, 1'b0, 1'b0, 32'h0,        7);
        vecs[31] = mk(OP_MFHI,  32'h0,        32'h0,        1'b0, 1'b0, 32'h00000002, 7);
        vecs[32] = mk(OP_MFLO,  32'h0,        32'h0,        1'b0, 1'b0, 32'hfffffff1, 0);

        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_rs    = '0;
        req_rt    = '0;
        flush     = 1'b0;
        late_mode = 1'b0;
        wd_valid  = 1'b0;
        wd_op     = '0;

        // Reset values while reset is held.
        @(negedge clk);
        check("rst_md_start",   64'(md_start),   64'(0));
        check("rst_md_A",       64'(md_A),       64'(0));
        check("rst_md_B",       64'(md_B),       64'(0));
        check("rst_md_Op",      64'(md_Op),      64'(0));
        check("rst_md_timeout", 64'(md_timeout), 64'(0));
        check("rst_rd_valid",   64'(rd_valid),   64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven main sequence.
        for (int i = 0; i < 33; i++) begin
            if (!vecs[i].op[2] && !vecs[i].fl) late_mode = vecs[i].late;
            issue(i, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].fl, vecs[i].exp_rd,
                  vecs[i].exp_stall);
        end

        // Reset in the middle of a DIV; the unit keeps running on its own.
        late_mode = 1'b0;
        issue(100, OP_DIV, 32'd100, 32'd7, 1'b0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_md_start",   64'(md_start),   64'(0));
        check("midrst_md_A",       64'(md_A),       64'(0));
        check("midrst_md_B",       64'(md_B),       64'(0));
        check("midrst_md_Op",      64'(md_Op),      64'(0));
        check("midrst_md_timeout", 64'(md_timeout), 64'(0));
        check("midrst_unit_busy",  64'(md_BUSY),    64'(1));
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        issue(101, OP_MFLO, 32'h0, 32'h0, 1'b0, 32'h00000000, 0);
        issue(102, OP_MULT, 32'd6, 32'd7, 1'b0, 32'h0, 7);
        issue(103, OP_MFLO, 32'h0, 32'h0, 1'b0, 32'h0000002a, 7);
        issue(104, OP_MFHI, 32'h0, 32'h0, 1'b0, 32'h00000000, 0);

        // Watchdog instance with MAX_CYC=8.
        wd_valid = 1'b1;
        wd_op    = OP_MULT;
        @(negedge clk);
        check("wd_mult_ready", 64'(wd_ready), 64'(1));
        @(posedge clk);
        #1 wd_valid = 1'b0;
        @(negedge clk);
        check("wd_start", 64'(wd_start), 64'(1));
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("wd_timeout_before_limit", 64'(wd_timeout), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("wd_timeout_at_limit", 64'(wd_timeout), 64'(1));
        @(posedge clk);
        #1;
        wd_valid = 1'b1;
        wd_op    = OP_MFHI;
        @(negedge clk);
        check("wd_mfhi_ready", 64'(wd_ready),    64'(1));
        check("wd_mfhi_valid", 64'(wd_rd_valid), 64'(1));
        check("wd_mfhi_data",  64'(wd_rd_data),  64'(0));
        @(posedge clk);
        #1 wd_op = OP_MFLO;
        @(negedge clk);
        check("wd_mflo_data", 64'(wd_rd_data), 64'(0));
        @(posedge clk);
        #1 wd_op = OP_MULT;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("wd_mult_stall%0d", k), 64'(wd_ready), 64'(0));
            check($sformatf("wd_no_start%0d", k),   64'(wd_start), 64'(0));
        end
        @(posedge clk);
        #1 wd_valid = 1'b0;
        @(negedge clk);
        check("wd_timeout_sticky", 64'(wd_timeout), 64'(1));

        repeat (2) @(negedge clk);
        check("rd_queue_empty",     64'(rd_q.size()),     64'(0));
        check("launch_queue_empty", 64'(launch_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Pipeline-side initiator for the MultDiv unit. It sits in the EX stage: it accepts decoded HI/LO-class instructions (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO), launches operations on MultDiv via `start`/`Op`, and tracks `BUSY`. It holds the architectural HI/LO shadow registers and stalls the pipeline whenever a request cannot be serviced.

## Interface
- `MAX_CYC`, default 64: watchdog limit, in cycles, for `md_BUSY` to stay high in RUN.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  EX stage holds a HI/LO-class instruction.
- `req_op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
- `req_rs`, `req_rt`  in  32 each  operands; `req_rs` is the source for MTHI/MTLO.
- `flush`  in  1  kill the current EX request (exception/interrupt).
- `req_ready`  out  1  request accepted this cycle; stall = `req_valid & ~req_ready`.
- `rd_valid`  out  1  MFHI/MFLO result valid this cycle.
- `rd_data`  out  32  MFHI/MFLO result.
- `md_A`, `md_B`  out  32 each  operands to MultDiv, registered.
- `md_start`  out  1  one-cycle launch pulse, registered.
- `md_Op`  out  2  00 mult, 01 multu, 10 div, 11 divu, registered.
- `md_BUSY`  in  1  from MultDiv.
- `md_HI`, `md_LO`  in  32 each  from MultDiv; valid once BUSY falls.
- `md_timeout`  out  1  sticky watchdog flag.

## Operation
FSM states: IDLE, LAUNCH, RUN.
- **IDLE**, with `req_valid & ~flush`:
  - MFHI/MFLO: `req_ready=1`, `rd_valid=1`, `rd_data` = shadow HI/LO, combinational in the same cycle.
  - MTHI/MTLO: `req_ready=1`; shadow HI/LO ← `req_rs` at the edge.
  - MULT..DIVU with `md_BUSY=0`: `req_ready=1`. At the edge, register `md_A=req_rs`, `md_B=req_rt`, `md_Op=req_op[1:0]`, and go to LAUNCH.
  - MULT..DIVU with `md_BUSY=1`: `req_ready=0`, stay in IDLE.
- **LAUNCH**: `md_start=1` for exactly this cycle. Go to RUN unconditionally. `req_ready=0`.
- **RUN**: `req_ready=0` for all ops, including MF/MT. Watchdog counter increments each cycle.
  - The first RUN cycle ignores `md_BUSY`, because the unit raises BUSY on the edge ending LAUNCH.
  - From the second RUN cycle, `md_BUSY=0` ⇒ shadow HI ← `md_HI`, LO ← `md_LO` at the edge; go to IDLE.
  - Counter reaching `MAX_CYC` with BUSY still high ⇒ `md_timeout` ← 1 (sticky until reset); go to IDLE with no capture.
- `flush` with `req_valid`: nothing happens (no start, no shadow write); `rd_valid=0`; `req_ready` is don't-care.
- `flush` in LAUNCH/RUN does not abort. MultDiv cannot be cancelled, so the result is still captured.
- `rd_valid=0` whenever no MF read is accepted. `rd_data` is 0 when `rd_valid=0`.

## Timing
- Reset (async assert, sync-safe deassert) values:
  - State IDLE; shadow HI/LO = 0.
  - `md_A`, `md_B`, `md_Op`, `md_start` = 0; watchdog count = 0; `md_timeout` = 0.
  - `req_ready` reflects IDLE rules.
- Mult/div accepted at edge T: `md_start` high during cycle T+1 (LAUNCH). RUN begins at T+2.
- BUSY observed low in RUN at cycle C: shadow updated at edge C. The earliest accepted MFHI is in cycle C+1.
- An MF/MT request arriving in the same cycle BUSY falls stalls one cycle and then reads the new value.
- Back-to-back mult/div: the second is accepted no earlier than the cycle after RUN exits.
- MTHI directly after MULT completes overwrites only HI; LO keeps the product.
- Reset mid-RUN: drop to IDLE, shadows = 0. A stale `md_BUSY=1` blocks new mult/div (stall) until it falls. Its late HI/LO is never captured.
- Watchdog: `md_timeout` rises at edge number `MAX_CYC` counted from entering RUN.

## Test plan
Bench uses a behavioural MultDiv: BUSY high 5 cycles for mult, 10 cycles for div, starting the edge after `start`.
- MULTU rs=7fffffff rt=ffffffff, then MFHI, MFLO:
  - `md_Op=01` with a single `md_start` pulse.
  - MFHI stalls until capture, then returns 7ffffffe; MFLO returns 80000001.
- MULT same operands: HI=ffffffff, LO=80000001. `req_ready=0` for every RUN cycle, including an MFLO issued during RUN.
- DIV rs=00000007 rt=fffffffe, then MFLO/MFHI: LO=fffffffd, HI=00000001. No capture during the first RUN cycle.
- MTHI rs=12345678 in IDLE, then MFHI the next cycle returns 12345678 with `rd_valid=1` and no stall. MTLO during RUN stalls until IDLE.
- Flush and reset:
  - MULT with `flush=1` ⇒ no `md_start`, shadows unchanged.
  - Reset asserted mid-DIV ⇒ outputs at reset values; a following MULT stalls until the model's BUSY drops.
- Watchdog with `MAX_CYC=8` and a model holding BUSY forever ⇒ `md_timeout=1` after 8 RUN cycles, back to IDLE, shadows unchanged, further mult stalls.
